// File: rtl/fetch_pkg.sv
// Shared types and next-PC arithmetic for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned CALC_W = 32;

  // Operands arrive zero-extended to CALC_W; the caller truncates the result
  // to PC_W, which gives modulo-2^PC_W wrap for any PC_W up to CALC_W.
  function automatic logic [CALC_W-1:0] next_pc(
    input logic [CALC_W-1:0] pc,
    input logic [CALC_W-1:0] off,
    input int unsigned       off_w,
    input logic              taken
  );
    logic [CALC_W-1:0] sext;
    logic [CALC_W-1:0] inc;
    int unsigned       sh;
    sh   = CALC_W - off_w;
    sext = $signed(off << sh) >>> sh;
    inc  = pc + 32'd1;
    if (taken) begin
      next_pc = inc + sext;
    end else begin
      next_pc = inc;
    end
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational sequential/branch-target address for the fetch sequencer.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] branch_off,
  input  logic             branch_taken,
  output logic [PC_W-1:0]  next_pc
);

  logic [CALC_W-1:0] next_wide_s;

  assign next_wide_s = fetch_pkg::next_pc(CALC_W'(pc), CALC_W'(branch_off), OFF_W, branch_taken);
  assign next_pc     = next_wide_s[PC_W-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: FETCH/HOLD/HALT FSM owning pc and the instruction register.
// Optional retire counter enabled by defining FETCH_SEQ_RETIRE_CNT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned    PC_W     = 16,
  parameter int unsigned    INSTR_W  = 16,
  parameter int unsigned    OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_accept,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_off,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  output logic [31:0]        retire_cnt,
`endif
  output logic               halted
);

  fetch_state_e       state_r, state_nxt_s;
  logic [PC_W-1:0]    pc_r, pc_nxt_s, next_pc_s;
  logic [INSTR_W-1:0] instr_r, instr_nxt_s;

  fetch_next_pc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc           (pc_r),
    .branch_off   (branch_off),
    .branch_taken (branch_taken),
    .next_pc      (next_pc_s)
  );

  // Next-state, pc and instruction-register update.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    case (state_r)
      ST_FETCH: begin
        if (imem_ready) begin
          instr_nxt_s = imem_rdata;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (instr_accept) begin
          pc_nxt_s = next_pc_s;
          if (halt) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // State, pc and instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      instr_r <= {INSTR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
    end
  end

`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt_r;

  // Counts every accepted instruction, including the one that halts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_r <= 32'd0;
    end else if ((state_r == ST_HOLD) && instr_accept) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`endif

  // Outputs decode registered state only.
  assign imem_req    = (state_r == ST_FETCH);
  assign imem_addr   = pc_r;
  assign instr_valid = (state_r == ST_HOLD);
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign halted      = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (RESET_PC = 0x0010).
// Also checks retire_cnt when FETCH_SEQ_RETIRE_CNT_EN is defined.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_accept;
  logic        branch_taken;
  logic [7:0]  branch_off;
  logic        halt;
  logic [15:0] pc;
  logic        halted;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(
    .PC_W     (16),
    .INSTR_W  (16),
    .OFF_W    (8),
    .RESET_PC (16'h0010)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_accept (instr_accept),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .halt         (halt),
    .pc           (pc),
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    .retire_cnt   (retire_cnt),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in FETCH with ready high: fetch, then accept with the given branch/halt.
  task automatic fetch_and_accept(input logic tk, input logic [7:0] off, input logic hl,
                                  input logic [15:0] exp_pc);
    instr_accept = 1'b1;
    branch_taken = tk;
    branch_off   = off;
    halt         = hl;
    step();
    check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
    step();
    check_eq("next_pc", {16'd0, pc}, {16'd0, exp_pc});
    if (!hl) begin
      check_eq("next_addr", {16'd0, imem_addr}, {16'd0, exp_pc});
      check_eq("next_req", {31'd0, imem_req}, 32'd1);
    end else begin
      check_eq("halt_flag", {31'd0, halted}, 32'd1);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = 16'h0000;
    instr_accept = 1'b0;
    branch_taken = 1'b0;
    branch_off   = 8'h00;
    halt         = 1'b0;
    @(posedge clk);
    step();
    check_eq("rst_req", {31'd0, imem_req}, 32'd1);
    check_eq("rst_pc", {16'd0, pc}, 32'h0010);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", {16'd0, instr}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);

    // Basic fetch, ready high and immediate accept.
    rst_n        = 1'b1;
    imem_ready   = 1'b1;
    imem_rdata   = 16'hA5A5;
    instr_accept = 1'b1;
    check_eq("f0_addr", {16'd0, imem_addr}, 32'h0010);
    step();
    check_eq("f0_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("f0_instr", {16'd0, instr}, 32'hA5A5);
    check_eq("f0_req_low", {31'd0, imem_req}, 32'd0);
    step();
    check_eq("f1_addr", {16'd0, imem_addr}, 32'h0011);
    check_eq("f1_valid", {31'd0, instr_valid}, 32'd0);
    step();
    check_eq("f1_valid_hi", {31'd0, instr_valid}, 32'd1);
    step();
    check_eq("f2_addr", {16'd0, imem_addr}, 32'h0012);

    // Wait states: ready low for 3 cycles.
    imem_ready = 1'b0;
    imem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      check_eq("ws_req", {31'd0, imem_req}, 32'd1);
      check_eq("ws_addr", {16'd0, imem_addr}, 32'h0012);
      step();
    end
    check_eq("ws_req4", {31'd0, imem_req}, 32'd1);
    check_eq("ws_valid_lo", {31'd0, instr_valid}, 32'd0);
    imem_ready   = 1'b1;
    instr_accept = 1'b0;
    step();
    check_eq("ws_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("ws_instr", {16'd0, instr}, 32'h1234);

    // Backpressure: accept low, rdata changing.
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 16'hBEE0 + 16'(i);
      step();
      check_eq("bp_instr", {16'd0, instr}, 32'h1234);
      check_eq("bp_req", {31'd0, imem_req}, 32'd0);
      check_eq("bp_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Accept in HOLD at 0x0012, branch +0x0D to land at 0x0020.
    instr_accept = 1'b1;
    branch_taken = 1'b1;
    branch_off   = 8'h0D;
    step();
    check_eq("br_to_20", {16'd0, imem_addr}, 32'h0020);

    fetch_and_accept(1'b1, 8'hFE, 1'b0, 16'h001F);  // backward branch
    fetch_and_accept(1'b1, 8'hDF, 1'b0, 16'hFFFF);  // 0x20 - 0x21
    fetch_and_accept(1'b1, 8'h01, 1'b0, 16'h0001);  // wraps past 0xFFFF
    fetch_and_accept(1'b1, 8'h1E, 1'b0, 16'h0020);
    fetch_and_accept(1'b0, 8'h7F, 1'b0, 16'h0021);  // not taken ignores offset
    fetch_and_accept(1'b1, 8'h0E, 1'b0, 16'h0030);
    fetch_and_accept(1'b1, 8'h04, 1'b1, 16'h0035);  // halt + branch together

    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("halt_req", {31'd0, imem_req}, 32'd0);
      check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("halt_pc", {16'd0, pc}, 32'h0035);
      check_eq("halt_stays", {31'd0, halted}, 32'd1);
    end
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    check_eq("retire_cnt", retire_cnt, 32'd10);
`endif

    // One-cycle reset with ready high: must come back in FETCH at RESET_PC.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rr_req", {31'd0, imem_req}, 32'd1);
    check_eq("rr_addr", {16'd0, imem_addr}, 32'h0010);
    check_eq("rr_halted", {31'd0, halted}, 32'd0);
    check_eq("rr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rr_instr", {16'd0, instr}, 32'd0);
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    check_eq("rr_retire_cnt", retire_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
